// File: rtl/noise_ctrl_pkg.sv
// Shared types and constants for the noise generator load/run controller.
package noise_ctrl_pkg;

  localparam int unsigned TableBytes    = 128;
  localparam int unsigned TableWords    = TableBytes / 8;
  localparam int unsigned AddrW         = 8;
  // Word address of the optional checksum word for a full table (right after the table).
  localparam int unsigned ChkWordOffset = TableWords;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StSettle,
    StRun,
    StDone
  } noise_ctrl_state_t;

endpackage

// File: rtl/noise_rd_tracker.sv
// Tracks outstanding OCM reads: a Depth-deep valid/address shift register.
module noise_rd_tracker
  import noise_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             flush_i,
  output logic             ret_valid_o,
  output logic [AddrW-1:0] ret_addr_o,
  output logic             empty_o
);

  logic [Depth-1:0] valid_q;
  logic [AddrW-1:0] addr_q [Depth];

  // Shift each issued read toward the return stage; flush drops everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) addr_q[i] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= issue_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign ret_valid_o = valid_q[Depth-1];
  assign ret_addr_o  = addr_q[Depth-1];

  // Empty means nothing remains outstanding once the current return (if any) is consumed.
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < int'(Depth) - 1; i++) begin
      if (valid_q[i]) empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/noise_load_ctrl.sv
// Noise generator sequencer: loads the distribution table from OCM, enables the
// generator, waits for done_wait and counts samples up to a programmed target.
// Optional: NOISE_LOAD_CHECKSUM_EN adds an XOR checksum word read after the table.
module noise_load_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WORDS = TableWords,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] sample_target_i,
  output logic             ocm_rd_en_o,
  output logic [AddrW-1:0] ocm_rd_addr_o,
  input  logic [63:0]      ocm_rd_data_i,
  output logic [63:0]      mem_data_o,
  output logic [AddrW-1:0] location_o,
  output logic             load_mem_o,
  input  logic             done_wait_i,
  output logic             noise_en_o,
  input  logic             noise_out_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] sample_cnt_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
`ifdef NOISE_LOAD_CHECKSUM_EN
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NUM_WORDS);
`else
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NUM_WORDS - 1);
`endif

  noise_ctrl_state_t state_q, state_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [63:0]       mem_data_q;
  logic [AddrW-1:0]  location_q;

  logic             trk_valid, trk_empty, fwd, ret_is_chk, chk_bad, accept;
  logic [AddrW-1:0] trk_addr;

  noise_rd_tracker #(
    .Depth (MEM_LAT)
  ) u_rd_tracker (
    .clk         (clk),
    .rstn        (rstn),
    .issue_i     (ocm_rd_en_o),
    .addr_i      (addr_q),
    .flush_i     (abort_i),
    .ret_valid_o (trk_valid),
    .ret_addr_o  (trk_addr),
    .empty_o     (trk_empty)
  );

  assign accept = (state_q == StIdle) & start_i & ~abort_i;

`ifdef NOISE_LOAD_CHECKSUM_EN
  logic [63:0] acc_q;

  assign ret_is_chk = (trk_addr == LastAddr);
  // The checksum word is always the last read, so it is returning when the tracker reports empty.
  assign chk_bad    = trk_valid & ret_is_chk & (acc_q != ocm_rd_data_i);

  // XOR-accumulate every forwarded table word of the current load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       acc_q <= '0;
    else if (accept) acc_q <= '0;
    else if (fwd)    acc_q <= acc_q ^ ocm_rd_data_i;
  end
`else
  assign ret_is_chk = 1'b0;
  assign chk_bad    = 1'b0;
`endif

  // Returns are discarded on abort; the checksum word never reaches the generator.
  assign fwd          = trk_valid & ~abort_i & ~ret_is_chk;
  assign load_mem_o   = fwd;
  assign mem_data_o   = fwd ? ocm_rd_data_i : mem_data_q;
  assign location_o   = fwd ? trk_addr : location_q;
  assign ocm_rd_addr_o = addr_q;
  assign busy_o       = (state_q != StIdle);
  assign err_o        = err_q;
  assign sample_cnt_o = cnt_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      target_q   <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      mem_data_q <= '0;
      location_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      if (fwd) begin
        mem_data_q <= ocm_rd_data_i;
        location_q <= trk_addr;
      end
    end
  end

  // Next-state and control outputs; abort overrides everything and leaves err alone.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    ocm_rd_en_o = 1'b0;
    noise_en_o  = 1'b0;
    done_o      = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      addr_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            target_d = sample_target_i;
            cnt_d    = '0;
            err_d    = 1'b0;
            addr_d   = '0;
            state_d  = StLoad;
          end
        end
        StLoad: begin
          ocm_rd_en_o = 1'b1;
          addr_d      = addr_q + 1'b1;
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (trk_empty) begin
            tmo_d = '0;
            if (chk_bad) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StSettle;
            end
          end
        end
        StSettle: begin
          noise_en_o = 1'b1;
          if (done_wait_i) begin
            state_d = StRun;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        StRun: begin
          noise_en_o = 1'b1;
          if (!done_wait_i) err_d = 1'b1;
          if (noise_out_valid_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
            if ((target_q != '0) && (cnt_q + 1'b1 == target_q)) state_d = StDone;
          end
        end
        StDone: begin
          done_o  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_load_ctrl.sv
// Directed bench for noise_load_ctrl: load timing, sample counting table, timeout,
// abort, ignored starts and (with NOISE_LOAD_CHECKSUM_EN) the checksum check.
module tb_noise_load_ctrl;

  localparam int unsigned NW  = 16;
  localparam int unsigned ML  = 2;
  localparam int unsigned TMO = 64;
  localparam int unsigned CW  = 32;
`ifdef NOISE_LOAD_CHECKSUM_EN
  localparam int unsigned NRD = NW + 1;
`else
  localparam int unsigned NRD = NW;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [CW-1:0] sample_target = '0;
  logic          ocm_rd_en;
  logic [7:0]    ocm_rd_addr;
  logic [63:0]   ocm_rd_data;
  logic [63:0]   mem_data;
  logic [7:0]    location;
  logic          load_mem;
  logic          done_wait = 1'b0, noise_out_valid = 1'b0;
  logic          noise_en, busy, done, err;
  logic [CW-1:0] sample_cnt;
  logic          chk_corrupt = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_lm;
  logic seen_ne;
  int k;

  typedef struct {
    logic          dw;
    logic          nv;
    logic          ne;
    logic          dn;
    logic          bs;
    logic          er;
    logic [CW-1:0] cnt;
  } vec_t;
  vec_t vec [12];

  always #5 clk = ~clk;

  noise_load_ctrl #(
    .NUM_WORDS (NW),
    .MEM_LAT   (ML),
    .TIMEOUT   (TMO),
    .CNT_W     (CW)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start_i           (start),
    .abort_i           (abort),
    .sample_target_i   (sample_target),
    .ocm_rd_en_o       (ocm_rd_en),
    .ocm_rd_addr_o     (ocm_rd_addr),
    .ocm_rd_data_i     (ocm_rd_data),
    .mem_data_o        (mem_data),
    .location_o        (location),
    .load_mem_o        (load_mem),
    .done_wait_i       (done_wait),
    .noise_en_o        (noise_en),
    .noise_out_valid_i (noise_out_valid),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
    .sample_cnt_o      (sample_cnt)
  );

  // OCM model: word k = {8{k}}, word NW = XOR of the table (inverted when corrupt).
  function automatic logic [63:0] ocm_word(input logic [7:0] a, input logic bad);
    logic [63:0] x;
    x = '0;
    if (a < NW) return {8{a}};
    for (int j = 0; j < int'(NW); j++) x = x ^ {8{8'(j)}};
    return bad ? ~x : x;
  endfunction

  logic [7:0] pa [ML];
  always @(posedge clk) begin
    pa[0] <= ocm_rd_addr;
    for (int i = 1; i < int'(ML); i++) pa[i] <= pa[i-1];
  end
  always_comb ocm_rd_data = ocm_word(pa[ML-1], chk_corrupt);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; one-shot pulses drop back to 0.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_noise_en(input string name);
    int n;
    n = 0;
    while (!noise_en && n < 100) begin
      step();
      #1;
      n++;
    end
    check(name, noise_en, 1'b1);
  endtask

  initial begin
    //             dw    nv    ne    dn    bs    er    cnt
    vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
    vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
    vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
    vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
    vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5};
    vec[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5};
    vec[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_noise_en", noise_en, 1'b0);
    check("rst_load_mem", load_mem, 1'b0);
    check("rst_rd_en", ocm_rd_en, 1'b0);
    check("rst_cnt", sample_cnt, '0);
    check("rst_mem_data", mem_data, '0);
    check("rst_location", location, '0);
    step();
    rstn = 1'b1;

    // Normal load: first rd_en is cycle 0, SETTLE at cycle NRD+ML
    step();
    sample_target = 5;
    done_wait = 1'b1;
    start = 1'b1;
    #1;
    check("idle_busy", busy, 1'b0);
    for (int i = 0; i <= int'(NRD + ML); i++) begin
      step();
      #1;
      check("ld_rd_en", ocm_rd_en, (i < int'(NRD)));
      if (i < int'(NRD)) check("ld_rd_addr", ocm_rd_addr, i);
      exp_lm = (i >= int'(ML)) && (i < int'(NW + ML));
      check("ld_load_mem", load_mem, exp_lm);
      if (exp_lm) begin
        check("ld_location", location, i - ML);
        check("ld_mem_data", mem_data, ocm_word(8'(i - ML), 1'b0));
      end
      check("ld_noise_en", noise_en, (i == int'(NRD + ML)));
      check("ld_busy", busy, 1'b1);
    end

    // RUN phase, target 5, valid every other cycle
    for (int r = 0; r < 12; r++) begin
      step();
      done_wait = vec[r].dw;
      noise_out_valid = vec[r].nv;
      #1;
      check("run_noise_en", noise_en, vec[r].ne);
      check("run_done", done, vec[r].dn);
      check("run_busy", busy, vec[r].bs);
      check("run_err", err, vec[r].er);
      check("run_cnt", sample_cnt, vec[r].cnt);
    end
    noise_out_valid = 1'b0;

    // Timeout: done_wait held low
    step();
    done_wait = 1'b0;
    sample_target = 3;
    start = 1'b1;
    #1;
    wait_noise_en("tmo_settle");
    check("tmo_err_cleared", err, 1'b0);
    k = 0;
    while (!done && k < int'(TMO) + 10) begin
      step();
      #1;
      k++;
    end
    check("tmo_cycles", k, TMO);
    check("tmo_err", err, 1'b1);
    check("tmo_noise_en", noise_en, 1'b0);
    step();
    #1;
    check("tmo_idle_busy", busy, 1'b0);
    check("tmo_err_sticky", err, 1'b1);
    check("tmo_noise_en_after", noise_en, 1'b0);

    // Abort on the 3rd return during LOAD
    step();
    done_wait = 1'b1;
    start = 1'b1;
    #1;
    for (int i = 0; i <= int'(ML) + 2; i++) begin
      step();
      if (i == int'(ML) + 2) abort = 1'b1;
      #1;
      check("ab_load_mem", load_mem, (i >= int'(ML)) && (i < int'(ML) + 2));
    end
    check("ab_rd_en", ocm_rd_en, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check("ab_discard", load_mem, 1'b0);
      check("ab_busy", busy, 1'b0);
      check("ab_done", done, 1'b0);
    end

    // Reload from location 0; start while busy must not relatch the target
    step();
    sample_target = 3;
    start = 1'b1;
    #1;
    for (int i = 0; i < int'(NRD); i++) begin
      step();
      if (i == 5) begin
        start = 1'b1;
        sample_target = 1;
      end
      #1;
      check("rl_rd_addr", ocm_rd_addr, i);
      if (i == int'(ML)) begin
        check("rl_first_lm", load_mem, 1'b1);
        check("rl_first_loc", location, 0);
      end
    end
    wait_noise_en("rl_settle");
    step();
    noise_out_valid = 1'b1;
    #1;
    check("rl_run_cnt0", sample_cnt, 0);
    step();
    done_wait = 1'b0;
    #1;
    check("rl_not_relatched", done, 1'b0);
    check("rl_cnt1", sample_cnt, 1);
    step();
    done_wait = 1'b1;
    #1;
    check("rl_dw_drop_err", err, 1'b1);
    check("rl_run_continues", noise_en, 1'b1);
    check("rl_cnt2", sample_cnt, 2);
    step();
    noise_out_valid = 1'b0;
    start = 1'b1;
    #1;
    check("rl_done", done, 1'b1);
    check("rl_cnt3", sample_cnt, 3);
    step();
    #1;
    check("done_start_ignored", busy, 1'b0);
    check("rl_err_sticky", err, 1'b1);

    // Abort beats the final sample; err unchanged by abort
    step();
    sample_target = 2;
    start = 1'b1;
    #1;
    wait_noise_en("af_settle");
    step();
    noise_out_valid = 1'b1;
    done_wait = 1'b0;
    #1;
    step();
    done_wait = 1'b1;
    abort = 1'b1;
    #1;
    check("af_noise_en_abort", noise_en, 1'b0);
    check("af_done_abort", done, 1'b0);
    noise_out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("af_busy", busy, 1'b0);
      check("af_no_done", done, 1'b0);
      check("af_err_kept", err, 1'b1);
    end

    // Start coincident with abort in IDLE: ignored, err not cleared
    step();
    start = 1'b1;
    abort = 1'b1;
    sample_target = 9;
    #1;
    step();
    #1;
    check("sa_busy", busy, 1'b0);
    check("sa_err_kept", err, 1'b1);

`ifdef NOISE_LOAD_CHECKSUM_EN
    // Corrupt checksum: err, done pulse, generator never enabled
    chk_corrupt = 1'b1;
    step();
    start = 1'b1;
    #1;
    k = 0;
    seen_ne = 1'b0;
    while (!done && k < 200) begin
      step();
      #1;
      if (noise_en) seen_ne = 1'b1;
      k++;
    end
    check("ck_bad_done", done, 1'b1);
    check("ck_bad_err", err, 1'b1);
    check("ck_bad_no_en", seen_ne, 1'b0);
    step();
    chk_corrupt = 1'b0;
    #1;
    // Correct checksum reaches RUN
    step();
    start = 1'b1;
    #1;
    wait_noise_en("ck_ok_settle");
    step();
    #1;
    check("ck_ok_run", noise_en, 1'b1);
    check("ck_ok_err", err, 1'b0);
    step();
    abort = 1'b1;
    #1;
    step();
    #1;
    check("ck_ok_abort_idle", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
